// File: rtl/lut_sched_pkg.sv
// Shared types and sizing helpers for the time-multiplexed LUT layer scheduler.
package lut_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int cnt_width(input int num_neurons);
        return (num_neurons > 1) ? $clog2(num_neurons) : 1;
    endfunction

    function automatic int ram_depth(input int num_neurons, input int addr_w);
        return num_neurons << addr_w;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Shared truth-table store: one write port for configuration, one registered read port.
module lut_table_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2,
    parameter int DEPTH  = 2048
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // Contents are deliberately not reset; tables are loaded once after power-up.
    (* ram_style = "distributed" *) logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates NUM_NEURONS LUT neurons one per cycle from a single shared table RAM.
//   state | meaning
//   IDLE  | accept a vector or a table write (write wins a same-cycle conflict)
//   RUN   | issue one neuron read per cycle
//   DRAIN | capture the last neuron's read data
//   DONE  | hold the layer result until the downstream handshake
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter  int NUM_NEURONS = 8,
    parameter  int ADDR_W      = 8,
    parameter  int OUT_BITS    = 2,
    localparam int CNT_W       = cnt_width(NUM_NEURONS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   i_in_addr,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] o_out_vec,
    input  logic                            i_cfg_we,
    input  logic [CNT_W+ADDR_W-1:0]         i_cfg_addr,
    input  logic [OUT_BITS-1:0]             i_cfg_data,
    output logic                            o_cfg_ready
);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [CNT_W-1:0]                r_cnt;
    logic [NUM_NEURONS*ADDR_W-1:0]   r_in_addr;
    logic                            r_rd_vld;
    logic [CNT_W-1:0]                r_rd_idx;
    logic [NUM_NEURONS*OUT_BITS-1:0] r_out_vec;

    logic                            w_in_ready;
    logic                            w_out_valid;
    logic                            w_cfg_ready;
    logic                            w_accept;
    logic                            w_last;
    logic                            w_cfg_wr;
    logic [CNT_W-1:0]                w_cfg_idx;
    logic [ADDR_W-1:0]               w_rd_lut;
    logic [OUT_BITS-1:0]             w_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_cfg_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cfg_ready = 1'b1;
                w_in_ready  = ~i_cfg_we & ~i_rst;
                if (i_in_valid && w_in_ready) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = (r_state == ST_IDLE) && i_in_valid && w_in_ready;
    assign w_last    = (r_cnt == CNT_W'(NUM_NEURONS - 1));
    assign w_cfg_idx = i_cfg_addr[CNT_W+ADDR_W-1 -: CNT_W];
    // Indices past the last neuron only exist when NUM_NEURONS is not a power of two.
    assign w_cfg_wr  = w_cfg_ready && i_cfg_we && !i_rst && (int'(w_cfg_idx) < NUM_NEURONS);
    assign w_rd_lut  = r_in_addr[r_cnt*ADDR_W +: ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_in_addr <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_idx  <= '0;
            r_out_vec <= '0;
        end else begin
            r_rd_vld <= (r_state == ST_RUN);
            r_rd_idx <= r_cnt;
            if (w_accept) begin
                r_in_addr <= i_in_addr;
                r_cnt     <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            // Read data lags its address by one cycle, so slot index travels with it.
            if (r_rd_vld) begin
                r_out_vec[r_rd_idx*OUT_BITS +: OUT_BITS] <= w_rd_data;
            end
        end
    end

    lut_table_ram #(
        .ADDR_W (CNT_W + ADDR_W),
        .DATA_W (OUT_BITS),
        .DEPTH  (ram_depth(NUM_NEURONS, ADDR_W))
    ) u_table (
        .i_clk     (i_clk),
        .i_we      (w_cfg_wr),
        .i_wr_addr (i_cfg_addr),
        .i_wr_data (i_cfg_data),
        .i_rd_addr ({r_cnt, w_rd_lut}),
        .o_rd_data (w_rd_data)
    );

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_cfg_ready = w_cfg_ready;
    assign o_out_vec   = r_out_vec;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed and randomized checks of the LUT layer scheduler against a table-lookup model.
module tb_lut_layer_scheduler;

    localparam int N  = 8;
    localparam int AW = 8;
    localparam int OB = 2;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_in_valid;
    logic            o_in_ready;
    logic [N*AW-1:0] i_in_addr;
    logic            o_out_valid;
    logic            i_out_ready;
    logic [N*OB-1:0] o_out_vec;
    logic            i_cfg_we;
    logic [CW+AW-1:0] i_cfg_addr;
    logic [OB-1:0]   i_cfg_data;
    logic            o_cfg_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [OB-1:0] tbl [N][256];

    lut_layer_scheduler #(
        .NUM_NEURONS (N),
        .ADDR_W      (AW),
        .OUT_BITS    (OB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_addr   (i_in_addr),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_vec   (o_out_vec),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_data  (i_cfg_data),
        .o_cfg_ready (o_cfg_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N*OB-1:0] golden(input logic [N*AW-1:0] v);
        logic [N*OB-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k*OB +: OB] = tbl[k][v[k*AW +: AW]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int k, input int a, input logic [OB-1:0] d);
        i_cfg_we   = 1'b1;
        i_cfg_addr = {CW'(k), AW'(a)};
        i_cfg_data = d;
        tick();
        i_cfg_we   = 1'b0;
    endtask

    task automatic load_all(input bit rnd);
        logic [OB-1:0] d;
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 256; a++) begin
                d = rnd ? OB'($urandom) : OB'((a + k) % 4);
                tbl[k][a] = d;
                cfg_write(k, a, d);
            end
        end
    endtask

    task automatic send(input logic [N*AW-1:0] v, output int t_acc);
        i_in_valid = 1'b1;
        i_in_addr  = v;
        #1;
        check("in_ready_idle", 64'(o_in_ready), 64'(1));
        tick();
        t_acc      = cyc;
        i_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 1;
        while (!o_out_valid && lat < 4*N) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(N + 2));
    endtask

    task automatic handshake();
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        check("hs_out_valid_drop", 64'(o_out_valid), 64'(0));
        check("hs_in_ready", 64'(o_in_ready), 64'(1));
    endtask

    initial begin
        logic [N*AW-1:0] v10;
        logic [N*AW-1:0] v;
        logic [N*OB-1:0] exp1;
        logic [N*OB-1:0] exp4;
        int t_acc;
        int t_prev;
        bit seen_valid;

        rst         = 1'b1;
        i_in_valid  = 1'b0;
        i_in_addr   = '0;
        i_out_ready = 1'b0;
        i_cfg_we    = 1'b0;
        i_cfg_addr  = '0;
        i_cfg_data  = '0;
        v10         = {N{8'h10}};
        for (int k = 0; k < N; k++) exp1[k*OB +: OB] = OB'((16 + k) % 4);

        // reset state
        tick();
        tick();
        check("rst_in_ready", 64'(o_in_ready), 64'(0));
        check("rst_out_valid", 64'(o_out_valid), 64'(0));
        check("rst_out_vec", 64'(o_out_vec), 64'(0));
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(o_in_ready), 64'(1));
        check("idle_cfg_ready", 64'(o_cfg_ready), 64'(1));

        // 1: table (addr+k)%4, vector of 0x10, exact latency
        load_all(1'b0);
        send(v10, t_acc);
        wait_done("t1");
        check("t1_out_vec", 64'(o_out_vec), 64'(exp1));

        // 2: downstream stall holds the result
        for (int i = 0; i < 5; i++) begin
            check("t2_out_valid", 64'(o_out_valid), 64'(1));
            check("t2_out_vec", 64'(o_out_vec), 64'(exp1));
            check("t2_in_ready", 64'(o_in_ready), 64'(0));
            tick();
        end
        handshake();

        // 3: config writes outside IDLE are dropped
        send(v10, t_acc);
        i_cfg_we   = 1'b1;
        i_cfg_addr = {CW'(1), 8'h10};
        i_cfg_data = 2'd3;
        #1;
        check("t3_cfg_ready_run", 64'(o_cfg_ready), 64'(0));
        wait_done("t3a");
        i_cfg_we = 1'b0;
        check("t3a_out_vec", 64'(o_out_vec), 64'(exp1));
        handshake();
        send(v10, t_acc);
        wait_done("t3b");
        check("t3b_out_vec", 64'(o_out_vec), 64'(exp1));
        handshake();

        // 4: config write and vector in the same IDLE cycle
        i_cfg_we   = 1'b1;
        i_cfg_addr = {CW'(0), 8'h10};
        i_cfg_data = 2'd3;
        i_in_valid = 1'b1;
        i_in_addr  = v10;
        #1;
        check("t4_in_ready_conflict", 64'(o_in_ready), 64'(0));
        tick();
        tbl[0][8'h10] = 2'd3;
        i_cfg_we = 1'b0;
        #1;
        check("t4_in_ready_after", 64'(o_in_ready), 64'(1));
        tick();
        i_in_valid = 1'b0;
        wait_done("t4");
        exp4 = exp1;
        exp4[OB-1:0] = 2'd3;
        check("t4_out_vec", 64'(o_out_vec), 64'(exp4));
        check("t4_out_vec_model", 64'(o_out_vec), 64'(golden(v10)));
        handshake();

        // 5: reset during a run
        v = {$urandom, $urandom};
        send(v, t_acc);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_in_ready_rst", 64'(o_in_ready), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        check("t5_out_valid", 64'(o_out_valid), 64'(0));
        check("t5_out_vec", 64'(o_out_vec), 64'(0));
        check("t5_in_ready_idle", 64'(o_in_ready), 64'(1));
        check("t5_cfg_ready_idle", 64'(o_cfg_ready), 64'(1));
        seen_valid = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            seen_valid = seen_valid | o_out_valid;
            tick();
        end
        check("t5_no_out_valid", 64'(seen_valid), 64'(0));
        send(v, t_acc);
        wait_done("t5");
        check("t5_tables_intact", 64'(o_out_vec), 64'(golden(v)));
        handshake();

        // 6: random tables, back-to-back random vectors
        load_all(1'b1);
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            v = {$urandom, $urandom};
            send(v, t_acc);
            if (i > 0) check("t6_spacing", 64'(t_acc - t_prev), 64'(N + 3));
            wait_done("t6");
            check("t6_out_vec", 64'(o_out_vec), 64'(golden(v)));
            handshake();
            t_prev = t_acc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
